// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction RAM port, decode-side queue head, and redirect/status lines.
interface if_fetch_queue_if;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        out_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        halted;
    logic        align_fault;

    modport master (
        output inst_addr,
        input  inst_data,
        input  out_ready,
        input  branch_taken,
        input  branch_target,
        output out_valid,
        output out_inst,
        output out_pc,
        output halted,
        output align_fault
    );

    modport slave (
        input  inst_addr,
        output inst_data,
        output out_ready,
        output branch_taken,
        output branch_target,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        input  halted,
        input  align_fault
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, reads the instruction RAM, and buffers
// {pc, inst} pairs in a 2-entry queue ahead of decode, with branch flush and end-of-memory halt.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    if_fetch_queue_if.master fq
);
    localparam int unsigned DEPTH     = 2;
    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    entry_t      q [DEPTH];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic        fault;
    logic        pop_c;
    logic        push_c;
    logic        halted_c;
    logic        fetch_ok_c;

    assign pop_c      = (count != 2'd0) && fq.out_ready;
    assign fetch_ok_c = (pc <= LAST_ADDR);

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state; a redirect restarts fetch from any state
    always_comb begin
        state_nx = state;
        if (fq.branch_taken) begin
            state_nx = S_RUN;
        end else begin
            case (state)
                S_IDLE:  state_nx = S_RUN;
                S_RUN:   if (!fetch_ok_c) state_nx = S_HALT;
                default: state_nx = state;
            endcase
        end
    end

    // state-decoded controls; a full queue still accepts a push when the head leaves
    always_comb begin
        push_c   = 1'b0;
        halted_c = 1'b0;
        case (state)
            S_RUN:   push_c = !fq.branch_taken && fetch_ok_c &&
                              ((count != 2'd2) || pop_c);
            S_HALT:  halted_c = 1'b1;
            default: begin
                push_c   = 1'b0;
                halted_c = 1'b0;
            end
        endcase
    end

    // pc, queue storage and sticky alignment flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc    <= RESET_PC;
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            q[0]  <= '0;
            q[1]  <= '0;
            fault <= 1'b0;
        end else if (fq.branch_taken) begin
            pc    <= {fq.branch_target[31:2], 2'b00};
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            if (fq.branch_target[1:0] != 2'b00) begin
                fault <= 1'b1;
            end
        end else begin
            if (push_c) begin
                q[tail] <= '{pc: pc, inst: fq.inst_data};
                tail    <= ~tail;
                pc      <= pc + 32'd4;
            end
            if (pop_c) begin
                head <= ~head;
            end
            count <= count + 2'(push_c) - 2'(pop_c);
        end
    end

    assign fq.inst_addr   = pc;
    assign fq.out_valid   = (count != 2'd0);
    assign fq.out_inst    = (count != 2'd0) ? q[head].inst : 32'd0;
    assign fq.out_pc      = (count != 2'd0) ? q[head].pc   : 32'd0;
    assign fq.halted      = halted_c;
    assign fq.align_fault = fault;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: per-cycle vector table, randomised-stall scoreboard run,
// and an asynchronous mid-operation reset check.
module tb_if_fetch_queue;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;

    if_fetch_queue_if fq ();

    if_fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(256)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .fq     (fq)
    );

    always #5 clk = ~clk;

    // RAM model: two fixed words at 0/4, a distinct pattern elsewhere
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_0001;
        if (a == 32'h4) return 32'hE3A0_1002;
        return 32'hA500_0000 ^ a;
    endfunction

    assign fq.inst_data = ram_word(fq.inst_addr);

    typedef struct {
        logic        ready;
        logic        br;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [31:0] eaddr;
        logic        eh;
        logic        ef;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] exp_q[$];

    task automatic add(input logic ready, input logic br, input logic [31:0] tgt,
                       input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                       input logic eh, input logic ef);
        vec_t v;
        v.ready = ready; v.br = br; v.tgt = tgt;
        v.ev = ev; v.epc = epc; v.einst = ev ? ram_word(epc) : 32'd0;
        v.eaddr = eaddr; v.eh = eh; v.ef = ef;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        fq.out_ready = 1'b0;
        fq.branch_taken = 1'b0;
        fq.branch_target = 32'd0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        fq.out_ready = 1'b0;
        fq.branch_taken = 1'b0;
        fq.branch_target = 32'd0;

        // ready, br, tgt | valid, pc, addr, halted, fault  (one row per cycle after reset release)
        add(1, 0, 0,      0, 32'h00, 32'h000, 0, 0);
        add(1, 0, 0,      0, 32'h00, 32'h000, 0, 0);
        add(0, 0, 0,      1, 32'h00, 32'h004, 0, 0);
        add(0, 0, 0,      1, 32'h00, 32'h008, 0, 0);
        add(0, 0, 0,      1, 32'h00, 32'h008, 0, 0);
        add(1, 0, 0,      1, 32'h00, 32'h008, 0, 0);
        add(1, 0, 0,      1, 32'h04, 32'h00C, 0, 0);
        add(1, 0, 0,      1, 32'h08, 32'h010, 0, 0);
        add(0, 0, 0,      1, 32'h0C, 32'h014, 0, 0);
        add(1, 1, 32'h40, 1, 32'h0C, 32'h014, 0, 0);
        add(1, 0, 0,      0, 32'h00, 32'h040, 0, 0);
        add(1, 1, 32'hF8, 1, 32'h40, 32'h044, 0, 0);
        add(1, 0, 0,      0, 32'h00, 32'h0F8, 0, 0);
        add(1, 0, 0,      1, 32'hF8, 32'h0FC, 0, 0);
        add(1, 0, 0,      1, 32'hFC, 32'h100, 0, 0);
        add(1, 0, 0,      0, 32'h00, 32'h100, 1, 0);
        add(1, 1, 32'h22, 0, 32'h00, 32'h100, 1, 0);
        add(1, 0, 0,      0, 32'h00, 32'h020, 0, 1);
        add(1, 1, 32'h10, 1, 32'h20, 32'h024, 0, 1);
        add(1, 0, 0,      0, 32'h00, 32'h010, 0, 1);
        add(1, 0, 0,      1, 32'h10, 32'h014, 0, 1);

        do_reset();
        foreach (vecs[i]) begin
            fq.out_ready = vecs[i].ready;
            fq.branch_taken = vecs[i].br;
            fq.branch_target = vecs[i].tgt;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(fq.out_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d_pc", i), fq.out_pc, vecs[i].epc);
            chk($sformatf("v%0d_inst", i), fq.out_inst, vecs[i].einst);
            chk($sformatf("v%0d_addr", i), fq.inst_addr, vecs[i].eaddr);
            chk($sformatf("v%0d_halted", i), 32'(fq.halted), 32'(vecs[i].eh));
            chk($sformatf("v%0d_fault", i), 32'(fq.align_fault), 32'(vecs[i].ef));
            @(negedge clk);
        end

        // scoreboard run: full memory in order under random stalls
        do_reset();
        for (int a = 0; a < 256; a += 4) exp_q.push_back(32'(a));
        for (int cyc = 0; cyc < 800 && exp_q.size() != 0; cyc++) begin
            fq.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (fq.out_valid && fq.out_ready) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", fq.out_pc, e);
                chk("sb_inst", fq.out_inst, ram_word(e));
            end
            @(negedge clk);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d entries never delivered, expected 0", exp_q.size());
        end
        fq.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("sb_halted", 32'(fq.halted), 32'd1);
        chk("sb_addr", fq.inst_addr, 32'h100);
        chk("sb_valid", 32'(fq.out_valid), 32'd0);

        // fill queue after a misaligned redirect, then reset between edges
        fq.out_ready = 1'b0;
        fq.branch_taken = 1'b1;
        fq.branch_target = 32'h31;
        @(negedge clk);
        fq.branch_taken = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_valid", 32'(fq.out_valid), 32'd1);
        chk("pre_pc", fq.out_pc, 32'h30);
        chk("pre_addr", fq.inst_addr, 32'h38);
        chk("pre_fault", 32'(fq.align_fault), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(fq.out_valid), 32'd0);
        chk("rst_pc", fq.out_pc, 32'd0);
        chk("rst_inst", fq.out_inst, 32'd0);
        chk("rst_addr", fq.inst_addr, 32'd0);
        chk("rst_fault", 32'(fq.align_fault), 32'd0);
        chk("rst_halted", 32'(fq.halted), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
